// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU and DMA requester ports plus the shared RAM port.
// The slave modport is the arbiter side and the master modport is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic [1:0]    cpu_cmd;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic [1:0]    dma_cmd;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ready;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_cmd, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  dma_cmd, dma_addr, dma_wdata,
    output dma_rdata, dma_ready,
    output mem_cmd, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_cmd, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output dma_cmd, dma_addr, dma_wdata,
    input  dma_rdata, dma_ready,
    input  mem_cmd, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) arbiter for a single-port RAM: IDLE -> ACCESS (-> RESP on reads).
// Ties are round-robin by default; defining MEM_ARB_CPU_PRIO_EN makes the CPU always win.
module mem_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic clk,
  input  logic reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_ILL   = 2'b11
  } cmd_e;
  typedef enum logic {REQ_CPU, REQ_DMA} req_e;

  state_e        state_q;
  req_e          win_q;
  logic [1:0]    cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [1:0]    mem_cmd_q;
  logic          cpu_ready_q;
  logic          dma_ready_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dma_rdata_q;
`ifndef MEM_ARB_CPU_PRIO_EN
  req_e          last_grant_q;
`endif

  logic          cpu_req;
  logic          dma_req;
  req_e          win_d;
  logic [1:0]    cmd_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;

  always_comb begin
    cpu_req = (bus.cpu_cmd == CMD_READ) || (bus.cpu_cmd == CMD_WRITE);
    dma_req = (bus.dma_cmd == CMD_READ) || (bus.dma_cmd == CMD_WRITE);
`ifdef MEM_ARB_CPU_PRIO_EN
    win_d = cpu_req ? REQ_CPU : REQ_DMA;
`else
    win_d = REQ_CPU;
    if (dma_req && (!cpu_req || (last_grant_q == REQ_CPU))) win_d = REQ_DMA;
`endif
    cmd_d   = (win_d == REQ_DMA) ? bus.dma_cmd   : bus.cpu_cmd;
    addr_d  = (win_d == REQ_DMA) ? bus.dma_addr  : bus.cpu_addr;
    wdata_d = (win_d == REQ_DMA) ? bus.dma_wdata : bus.cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      win_q        <= REQ_CPU;
      cmd_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_cmd_q    <= CMD_NONE;
      cpu_ready_q  <= 1'b0;
      dma_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
`ifndef MEM_ARB_CPU_PRIO_EN
      last_grant_q <= REQ_DMA;
`endif
    end else begin
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req || dma_req) begin
            win_q     <= win_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mem_cmd_q <= cmd_d;
            // Writes complete in ACCESS, so their ready is armed at grant time.
            if (cmd_d == CMD_WRITE) begin
              cpu_ready_q <= (win_d == REQ_CPU);
              dma_ready_q <= (win_d == REQ_DMA);
            end
            state_q <= ACCESS;
`ifndef MEM_ARB_CPU_PRIO_EN
            last_grant_q <= win_d;
`endif
          end
        end
        ACCESS: begin
          if (cmd_q == CMD_WRITE) begin
            mem_cmd_q <= CMD_NONE;
            state_q   <= IDLE;
          end else begin
            cpu_ready_q <= (win_q == REQ_CPU);
            dma_ready_q <= (win_q == REQ_DMA);
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (win_q == REQ_CPU) cpu_rdata_q <= bus.mem_rdata;
          else                  dma_rdata_q <= bus.mem_rdata;
          mem_cmd_q <= CMD_NONE;
          state_q   <= IDLE;
        end
        default: begin
          mem_cmd_q <= CMD_NONE;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  logic mem_active;
  logic resp_live;

  // RAM data only arrives in RESP, so the winner sees it directly that cycle
  // and the registered copy holds it from then on.
  always_comb begin
    mem_active    = reset && (mem_cmd_q != CMD_NONE);
    resp_live     = reset && (state_q == RESP);
    bus.mem_cmd   = mem_active ? mem_cmd_q : CMD_NONE;
    bus.mem_addr  = mem_active ? addr_q    : '0;
    bus.mem_wdata = mem_active ? wdata_q   : '0;
    bus.cpu_ready = reset && cpu_ready_q;
    bus.dma_ready = reset && dma_ready_q;
    bus.cpu_rdata = (resp_live && (win_q == REQ_CPU)) ? bus.mem_rdata : cpu_rdata_q;
    bus.dma_rdata = (resp_live && (win_q == REQ_DMA)) ? bus.mem_rdata : dma_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model queues expected grants,
// and a negedge monitor checks the RAM bus, ready pulses and rdata against them.
module tb_mem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam logic [1:0] C_NONE = 2'b00, C_READ = 2'b01, C_WRITE = 2'b10, C_ILL = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            who;      // 0 = CPU, 1 = DMA
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            g;        // grant (sampling) cycle
    int            rdy;      // cycle of the ready pulse
  } exp_t;

  typedef struct {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            scr;      // 0 hold, 1 drop to NONE after grant, 2 junk after grant
  } op_t;

  exp_t sb[$];
  op_t  cpu_ops[$];
  op_t  dma_ops[$];

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_rd[2];

  function automatic logic [DW-1:0] ram_word(logic [AW-1:0] a);
    return {~a, a} ^ 16'h3C96;
  endfunction

  // RAM stand-in: data for a READ appears one cycle after it is presented, junk otherwise.
  always @(posedge clk)
    bus.mem_rdata <= (bus.mem_cmd == C_READ) ? ram_word(bus.mem_addr) : 16'($urandom);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t f;
    bit   has;
    logic [1:0] exp_cmd;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_mem_cmd", bus.mem_cmd, C_NONE);
        chk("rst_cpu_ready", bus.cpu_ready, 0);
        chk("rst_dma_ready", bus.dma_ready, 0);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
      end else begin
        has = (sb.size() != 0);
        if (has) f = sb[0];
        exp_cmd = (has && cyc > f.g && cyc <= f.rdy) ? f.cmd : C_NONE;
        chk("mem_cmd", bus.mem_cmd, exp_cmd);
        if (exp_cmd == C_NONE) begin
          chk("mem_addr_idle", bus.mem_addr, 0);
          chk("mem_wdata_idle", bus.mem_wdata, 0);
        end else begin
          chk("mem_addr", bus.mem_addr, f.addr);
          if (f.cmd == C_WRITE) chk("mem_wdata", bus.mem_wdata, f.wdata);
        end
        if (bus.cpu_ready || bus.dma_ready) begin
          if (!has) begin
            tests++;
            fails++;
            $display("FAIL spurious_ready @cycle %0d: actual cpu=%0b dma=%0b required none",
                     cyc, bus.cpu_ready, bus.dma_ready);
          end else begin
            chk("ready_cpu", bus.cpu_ready, (f.who == 1'b0));
            chk("ready_dma", bus.dma_ready, (f.who == 1'b1));
            chk("ready_cycle", cyc, f.rdy);
            if (f.cmd == C_READ) exp_rd[f.who] = f.rdata;
            void'(sb.pop_front());
          end
        end else if (has && cyc >= f.rdy) begin
          tests++;
          fails++;
          $display("FAIL missing_ready @cycle %0d: actual none required %s ready",
                   cyc, f.who ? "dma" : "cpu");
          void'(sb.pop_front());
        end
        chk("cpu_rdata", bus.cpu_rdata, exp_rd[0]);
        chk("dma_rdata", bus.dma_rdata, exp_rd[1]);
      end
    end
  end

  // ---------------- stimulus + reference model ----------------
  bit   pend[2];
  bit   granted[2];
  int   done[2];
  op_t  cur[2];
  int   next_free = 0;
  bit   last_dma = 1'b1;
  bit   rand_mode = 1'b0;

  task automatic drive(int r, logic [1:0] c, logic [AW-1:0] a, logic [DW-1:0] d);
    if (r == 0) begin
      bus.cpu_cmd = c; bus.cpu_addr = a; bus.cpu_wdata = d;
    end else begin
      bus.dma_cmd = c; bus.dma_addr = a; bus.dma_wdata = d;
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    int  k = $urandom_range(0, 9);
    o.cmd   = (k < 4) ? C_NONE : (k < 6) ? C_READ : (k < 9) ? C_WRITE : C_ILL;
    o.addr  = AW'($urandom);
    o.wdata = DW'($urandom);
    o.scr   = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0;
    return o;
  endfunction

  task automatic next_op(int r, output op_t o);
    if (r == 0 && cpu_ops.size() != 0)      o = cpu_ops.pop_front();
    else if (r == 1 && dma_ops.size() != 0) o = dma_ops.pop_front();
    else if (rand_mode)                     o = rand_op();
    else                                    o = '{C_NONE, '0, '0, 0};
  endtask

  task automatic cycle_step();
    op_t  o;
    exp_t e;
    bit   cr, dr, w;
    int   lat;
    for (int r = 0; r < 2; r++) begin
      if (pend[r] && granted[r] && cyc > done[r]) pend[r] = 1'b0;
      if (!pend[r]) begin
        next_op(r, o);
        cur[r]     = o;
        drive(r, o.cmd, o.addr, o.wdata);
        pend[r]    = (o.cmd == C_READ) || (o.cmd == C_WRITE);
        granted[r] = 1'b0;
      end else if (granted[r] && cur[r].scr == 1) begin
        drive(r, C_NONE, '0, '0);
      end else if (granted[r] && cur[r].scr == 2) begin
        drive(r, 2'($urandom), AW'($urandom), DW'($urandom));
      end
    end
    if (rst_n && cyc >= next_free) begin
      cr = pend[0] && !granted[0];
      dr = pend[1] && !granted[1];
      if (cr || dr) begin
`ifdef MEM_ARB_CPU_PRIO_EN
        w = !cr;
`else
        w = (cr && dr) ? !last_dma : dr;
`endif
        last_dma  = w;
        lat       = (cur[w].cmd == C_WRITE) ? 1 : 2;
        e.who     = w;
        e.cmd     = cur[w].cmd;
        e.addr    = cur[w].addr;
        e.wdata   = cur[w].wdata;
        e.rdata   = ram_word(cur[w].addr);
        e.g       = cyc;
        e.rdy     = cyc + lat;
        next_free = cyc + lat + 1;
        granted[w] = 1'b1;
        done[w]    = e.rdy;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle_step();
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    sb.delete();
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0;
      granted[r] = 1'b0;
      cur[r] = '{C_NONE, '0, '0, 0};
      drive(r, C_NONE, '0, '0);
    end
    next_free = 0;
    last_dma  = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    drive(0, C_NONE, '0, '0);
    drive(1, C_NONE, '0, '0);
    do_reset(3);

    // single CPU write, then single DMA read
    cpu_ops.push_back('{C_WRITE, 8'h05, 16'hABCD, 0});
    run(6);
    dma_ops.push_back('{C_READ, 8'h05, 16'h0000, 0});
    run(6);

    // contention: both requesters keep reading
    for (int i = 0; i < 4; i++) begin
      cpu_ops.push_back('{C_READ, AW'(8'h30 + i), 16'h0000, 0});
      dma_ops.push_back('{C_READ, AW'(8'h40 + i), 16'h0000, 0});
    end
    run(30);

    // granted CPU read whose command drops right after the grant
    cpu_ops.push_back('{C_READ, 8'h10, 16'h0000, 1});
    run(6);

    // illegal DMA command for 10 cycles
    for (int i = 0; i < 10; i++) dma_ops.push_back('{C_ILL, 8'h77, 16'h1234, 0});
    run(12);

    // reset in cycle 1 of a CPU read, then a tie right after release
    cpu_ops.push_back('{C_READ, 8'h20, 16'h0000, 0});
    run(1);
    do_reset(1);
    cpu_ops.push_back('{C_WRITE, 8'h21, 16'h5555, 0});
    dma_ops.push_back('{C_WRITE, 8'h22, 16'hAAAA, 0});
    run(8);

    // randomized traffic, then drain
    rand_mode = 1'b1;
    run(3000);
    rand_mode = 1'b0;
    run(12);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 8, address width; DW, default 16, data width.
REQ-002 Command encoding SHALL be: 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 illegal.
REQ-003 The block SHALL have one clock and synchronous, active-low reset; ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-low reset
- cpu_cmd  in  2  CPU command
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data
- cpu_ready  out  1  CPU completion pulse
- dma_cmd  in  2  DMA command
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_rdata  out  DW  DMA read data
- dma_ready  out  1  DMA completion pulse
- mem_cmd  out  2  RAM command
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid one cycle after READ is first presented

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-005 IDLE:
- mem_cmd SHALL be NONE.
- If any requester has a READ or WRITE command, the block SHALL pick a winner and latch its cmd, addr and wdata.
- The next state SHALL be ACCESS.
- Otherwise the block SHALL stay in IDLE.
REQ-006 Illegal command 2'b11 SHALL be treated as NONE and SHALL never be granted.
REQ-007 Tie-break SHALL be round-robin via a last_grant bit: the requester that did not win last SHALL win, and last_grant SHALL update on every grant.
REQ-008 ACCESS:
- mem_cmd, mem_addr and mem_wdata SHALL come from the latched values.
- On WRITE, the winner's ready SHALL pulse for this cycle and the next state SHALL be IDLE.
- On READ, the next state SHALL be RESP.
REQ-009 RESP:
- mem_cmd SHALL stay READ and mem_addr SHALL stay the latched address.
- The winner's rdata SHALL equal mem_rdata.
- The winner's ready SHALL pulse.
- The next state SHALL be IDLE.
REQ-010 Latency, counted from the IDLE cycle that samples the request as cycle 0:
- WRITE: ready in cycle 1.
- READ: ready in cycle 2.
- Minimum spacing between grants: 2 cycles (write), 3 cycles (read).
REQ-011 Each rdata output SHALL be registered and SHALL hold its last delivered value until that requester's next read completes.
REQ-012 The ready output of the non-granted requester SHALL be 0 in every cycle.
REQ-013 Requester inputs SHALL be ignored outside the IDLE sampling cycle.
- A cmd change or drop during ACCESS or RESP SHALL NOT alter the transaction in flight.
REQ-014 Requesters SHALL hold cmd stable until their ready pulse.
- A cmd still asserted in the IDLE cycle after ready SHALL be treated as a new request.
REQ-015 When mem_cmd is NONE, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-016 When reset is 0 at a clk edge, the block SHALL apply all of the following:
- state = IDLE.
- last_grant = DMA, so the CPU wins the first tie.
- cpu_rdata = dma_rdata = 0.
- Latched cmd, addr and wdata = 0.
REQ-017 While in reset, mem_cmd SHALL be NONE and both ready outputs SHALL be 0.
REQ-018 Reset asserted during ACCESS or RESP SHALL abort the transaction with no ready pulse; mem_cmd SHALL be NONE in the cycle after the reset edge.

Configuration
REQ-019 The macro MEM_ARB_CPU_PRIO_EN SHALL select the tie-break policy:
- Defined: the CPU SHALL always win ties, and last_grant SHALL be unused.
- Not defined: the round-robin policy of REQ-007 SHALL apply.

Verification
REQ-020 Single write: CPU WRITE addr=8'h05, wdata=16'hABCD → mem_cmd=WRITE with addr 05 and data ABCD in cycle 1; cpu_ready=1 in cycle 1 only.
REQ-021 Single read: DMA READ addr=8'h05, mem_rdata=16'hABCD → mem_cmd=READ in cycles 1-2; dma_ready=1 and dma_rdata=ABCD in cycle 2; cpu_ready=0 throughout.
REQ-022 Contention: both requesters hold READ continuously after reset → grants alternate CPU, DMA, CPU, DMA, with one ready pulse every 3 cycles. With MEM_ARB_CPU_PRIO_EN defined → CPU only.
REQ-023 Mid-flight change: CPU READ 8'h10 granted, then cpu_cmd drops to NONE in cycle 1 → the read still completes with cpu_ready in cycle 2; IDLE in cycle 3.
REQ-024 Illegal command: dma_cmd=2'b11, cpu_cmd=NONE for 10 cycles → mem_cmd stays NONE and no ready pulse occurs.
REQ-025 Reset mid-read: reset=0 in cycle 1 of a CPU read → no cpu_ready; mem_cmd=NONE in cycle 2; after release, the CPU wins the first tie.
